rr_bus_arbiter: RTL

Round-robin arbiter that shares one BUS_WIDTH-bit bus among NB_REQ requesters. Each requester drives its data bus and a request line. The arbiter grants the shared bus to exactly one requester at a time and holds that grant for a multi-cycle transaction. It merges the requester buses into the output by masking each with its grant bit and OR-reducing the results across requesters. It sits between bus masters (DMA, CPU load/store path, debug port) and a single shared slave bus.

---
 rtl/rr_bus_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter that hands one shared bus to a single
// requester at a time. A grant lasts for a multi-cycle transaction. The
// requester data buses are merged by masking each with its grant bit and
// OR-reducing the results. A one-cycle turnaround follows every release, and
// a hold limit stops any single requester from keeping the bus indefinitely.
module rr_bus_arbiter #(
    parameter int BUS_WIDTH = 8,
    parameter int NB_REQ    = 4,
    parameter int MAX_HOLD  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NB_REQ-1:0]             req,
    input  logic [NB_REQ-1:0]             last,
    input  logic [NB_REQ*BUS_WIDTH-1:0]   in_buses,
    output logic [NB_REQ-1:0]             grant,
    output logic                          grant_valid,
    output logic [$clog2(NB_REQ)-1:0]     grant_idx,
    output logic [BUS_WIDTH-1:0]          out_bus,
    output logic                          hold_expired
);

    localparam int IDX_W = $clog2(NB_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [NB_REQ-1:0] GRANT_ONE = {{(NB_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // Round-robin search: first set request starting at ptr+1, wrapping.
    // Returns {found, index}. The loop walks from the farthest offset down
    // to the nearest, so the nearest candidate is the last one written and
    // therefore the one that wins.
    function automatic logic [IDX_W:0] pick_next(input logic [NB_REQ-1:0] req_v,
                                                 input logic [IDX_W-1:0]  ptr_v);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cidx;
        int               cand;
        res = {(IDX_W+1){1'b0}};
        for (int off = NB_REQ; off >= 1; off--) begin
            cand = (int'(ptr_v) + off) % NB_REQ;
            cidx = IDX_W'(cand);
            if (req_v[cidx]) begin
                res = {1'b1, cidx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t              state_r,  state_nxt_s;
    logic [NB_REQ-1:0]   grant_r,  grant_nxt_s;
    logic [IDX_W-1:0]    idx_r,    idx_nxt_s;
    logic [IDX_W-1:0]    ptr_r,    ptr_nxt_s;
    logic [CNT_W-1:0]    cnt_r,    cnt_nxt_s;
    logic                expired_r, expired_nxt_s;
    logic [IDX_W:0]      pick_s;
    logic                holder_last_s;
    logic                holder_req_s;
    logic                at_limit_s;
    logic [BUS_WIDTH-1:0] out_bus_s;

    // State, grant, pointer and hold counter registers; reset clears the grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= {NB_REQ{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            ptr_r     <= IDX_W'(NB_REQ - 1);
            cnt_r     <= {CNT_W{1'b0}};
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            idx_r     <= idx_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
            expired_r <= expired_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE and at the end of TURN, hold and release in BUSY.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        idx_nxt_s     = idx_r;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        expired_nxt_s = 1'b0;
        pick_s        = pick_next(req, ptr_r);
        holder_last_s = last[idx_r];
        holder_req_s  = req[idx_r];
        at_limit_s    = (cnt_r == CNT_W'(MAX_HOLD));

        case (state_r)
            ST_IDLE, ST_TURN: begin
                // The turnaround cycle ends by arbitrating, so the earliest
                // new grant follows a single idle bus cycle.
                if (pick_s[IDX_W]) begin
                    state_nxt_s = ST_BUSY;
                    grant_nxt_s = GRANT_ONE << pick_s[IDX_W-1:0];
                    idx_nxt_s   = pick_s[IDX_W-1:0];
                    cnt_nxt_s   = CNT_W'(1'b1);
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = {NB_REQ{1'b0}};
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            ST_BUSY: begin
                if (holder_last_s || !holder_req_s || at_limit_s) begin
                    state_nxt_s   = ST_TURN;
                    grant_nxt_s   = {NB_REQ{1'b0}};
                    idx_nxt_s     = {IDX_W{1'b0}};
                    ptr_nxt_s     = idx_r;
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    // A last on the limit cycle counts as a normal finish.
                    expired_nxt_s = at_limit_s && !holder_last_s;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = {NB_REQ{1'b0}};
                idx_nxt_s   = {IDX_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Bus merge: mask each requester with its registered grant bit and OR them together.
    always_comb begin
        out_bus_s = {BUS_WIDTH{1'b0}};
        for (int i = 0; i < NB_REQ; i++) begin
            out_bus_s = out_bus_s | (in_buses[i*BUS_WIDTH +: BUS_WIDTH] & {BUS_WIDTH{grant_r[i]}});
        end
    end

    assign grant        = grant_r;
    assign grant_valid  = |grant_r;
    assign grant_idx    = idx_r;
    assign out_bus      = out_bus_s;
    assign hold_expired = expired_r;

endmodule
